// File: rtl/ofdm_sym_sched_pkg.sv
// ============================================================================
// Module : ofdm_pkg
// Desc   : Shared state encoding and default sizing for the OFDM symbol
//          scheduler.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package ofdm_pkg;

    localparam int SYM_IDX_W       = 6;
    localparam int DEF_N_SYM       = 14;
    localparam int DEF_GAP_CYC     = 2;
    localparam int DEF_TIMEOUT     = 200;
    localparam int GAP_CNT_W       = 4;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_WAIT_SYM = 3'd1,
        S_LOAD     = 3'd2,
        S_RUN      = 3'd3,
        S_GAP      = 3'd4,
        S_FIN      = 3'd5
    } sched_state_t;

endpackage

`default_nettype wire

// File: rtl/ofdm_sym_sched_cnt.sv
// ============================================================================
// Module : sched_cnt
// Desc   : Loadable down-counter that stops at zero and flags it.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module sched_cnt #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         en,
    input  logic [W-1:0] load_val,
    output logic         zero
);

    logic [W-1:0] r_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (load) begin
            r_count <= load_val;
        end else if (en && (r_count != '0)) begin
            r_count <= r_count - W'(1);
        end
    end

    assign zero = (r_count == '0);

endmodule

`default_nettype wire

// File: rtl/ofdm_sym_sched.sv
// ============================================================================
// Module : ofdm_sym_sched
// Desc   : Paces IFFT symbols into the CPI, one frame of N_SYM symbols per
//          frame_req. Macro SCHED_WATCHDOG_EN adds a RUN-state watchdog.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module ofdm_sym_sched
    import ofdm_pkg::*;
#(
    parameter int N_SYM   = DEF_N_SYM,
    parameter int GAP_CYC = DEF_GAP_CYC,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 frame_req,
    input  logic                 abort,
    input  logic                 sym_ready,
    input  logic                 cpi_done,
    output logic                 cpi_start,
    output logic                 cpi_data_valid,
    output logic [SYM_IDX_W-1:0] sym_idx,
    output logic                 busy,
    output logic                 frame_done,
    output logic                 overflow
`ifdef SCHED_WATCHDOG_EN
    ,
    output logic                 timeout_err
`endif
);

    localparam logic [SYM_IDX_W-1:0] c_last_idx = SYM_IDX_W'(N_SYM - 1);
    // GAP is entered already counting its first cycle, hence the minus one.
    localparam logic [GAP_CNT_W-1:0] c_gap_load = GAP_CNT_W'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);

    sched_state_t r_state;
    sched_state_t w_state_nxt;
    logic         r_pend;
    logic         w_gap_load;
    logic         w_gap_zero;
    logic         w_idx_inc;
    logic         w_clear;

    sched_cnt #(
        .W        (GAP_CNT_W)
    ) u_gap_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (w_gap_load),
        .en       (r_state == S_GAP),
        .load_val (c_gap_load),
        .zero     (w_gap_zero)
    );

`ifdef SCHED_WATCHDOG_EN
    localparam int            WD_W      = $clog2(TIMEOUT + 1);
    localparam logic [WD_W-1:0] c_wd_load = WD_W'(TIMEOUT - 1);

    logic w_wd_zero;
    logic w_wd_fire;

    sched_cnt #(
        .W        (WD_W)
    ) u_wd_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (r_state == S_LOAD),
        .en       (r_state == S_RUN),
        .load_val (c_wd_load),
        .zero     (w_wd_zero)
    );

    assign w_wd_fire = (r_state == S_RUN) && !cpi_done && w_wd_zero && !abort;
    assign w_clear   = abort || w_wd_fire;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            timeout_err <= 1'b0;
        end else if (w_wd_fire) begin
            timeout_err <= 1'b1;
        end
    end
`else
    assign w_clear = abort;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_gap_load  = 1'b0;
        w_idx_inc   = 1'b0;
        if (w_clear) begin
            w_state_nxt = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:     if (frame_req) w_state_nxt = S_WAIT_SYM;
                S_WAIT_SYM: if (sym_ready || r_pend) w_state_nxt = S_LOAD;
                S_LOAD:     w_state_nxt = S_RUN;
                S_RUN: begin
                    if (cpi_done) begin
                        if (sym_idx == c_last_idx) begin
                            w_state_nxt = S_FIN;
                        end else begin
                            w_idx_inc = 1'b1;
                            if (GAP_CYC == 0) begin
                                w_state_nxt = S_WAIT_SYM;
                            end else begin
                                w_state_nxt = S_GAP;
                                w_gap_load  = 1'b1;
                            end
                        end
                    end
                end
                S_GAP:      if (w_gap_zero) w_state_nxt = S_WAIT_SYM;
                S_FIN:      w_state_nxt = S_IDLE;
                default:    w_state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sym_idx  <= '0;
            r_pend   <= 1'b0;
            overflow <= 1'b0;
        end else if (w_clear) begin
            sym_idx <= '0;
            r_pend  <= 1'b0;
        end else begin
            if ((r_state == S_IDLE) && frame_req) begin
                sym_idx  <= '0;
                overflow <= 1'b0;
            end
            if (w_idx_inc) begin
                sym_idx <= sym_idx + SYM_IDX_W'(1);
            end
            // In WAIT_SYM a held symbol goes first; a fresh one arriving
            // alongside it replaces it in the pend slot and flags overflow.
            if (r_state == S_WAIT_SYM) begin
                if (r_pend && sym_ready) begin
                    overflow <= 1'b1;
                end else begin
                    r_pend <= 1'b0;
                end
            end else if ((r_state != S_IDLE) && sym_ready) begin
                if (r_pend) begin
                    overflow <= 1'b1;
                end else begin
                    r_pend <= 1'b1;
                end
            end
        end
    end

    assign cpi_start      = (r_state == S_LOAD) || (r_state == S_RUN);
    assign cpi_data_valid = (r_state == S_LOAD);
    assign busy           = (r_state != S_IDLE);
    assign frame_done     = (r_state == S_FIN);

endmodule

`default_nettype wire

// File: tb/tb_ofdm_sym_sched.sv
// ============================================================================
// Module : tb_ofdm_sym_sched
// Desc   : Self-checking bench for ofdm_sym_sched (N_SYM=3, GAP_CYC=2).
// Rev    : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_ofdm_sym_sched;

    localparam int N_SYM   = 3;
    localparam int GAP_CYC = 2;
    localparam int TIMEOUT = 200;

    localparam int P_IDLE = 0, P_WAIT = 1, P_LOAD = 2, P_RUN = 3, P_GAP = 4, P_FIN = 5;

    logic       clk = 1'b0;
    logic       rst, frame_req, abort, sym_ready, cpi_done;
    logic       cpi_start, cpi_data_valid, busy, frame_done, overflow, timeout_err;
    logic [5:0] sym_idx;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    ofdm_sym_sched #(
        .N_SYM          (N_SYM),
        .GAP_CYC        (GAP_CYC),
        .TIMEOUT        (TIMEOUT)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .frame_req      (frame_req),
        .abort          (abort),
        .sym_ready      (sym_ready),
        .cpi_done       (cpi_done),
        .cpi_start      (cpi_start),
        .cpi_data_valid (cpi_data_valid),
        .sym_idx        (sym_idx),
        .busy           (busy),
        .frame_done     (frame_done),
        .overflow       (overflow)
`ifdef SCHED_WATCHDOG_EN
        ,
        .timeout_err    (timeout_err)
`endif
    );

`ifndef SCHED_WATCHDOG_EN
    assign timeout_err = 1'b0;
`endif

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural reference: phase, symbol index, one-deep holding slot.
    int m_ph, m_idx, m_gap, m_run;
    bit m_pend, m_ovf, m_to;

    task note_sym();
        if (sym_ready) begin
            if (m_pend) m_ovf = 1'b1;
            else        m_pend = 1'b1;
        end
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_ph = P_IDLE; m_idx = 0; m_pend = 0; m_ovf = 0; m_gap = 0; m_run = 0; m_to = 0;
        end else if (abort) begin
            m_ph = P_IDLE; m_idx = 0; m_pend = 0;
        end else begin
            case (m_ph)
                P_IDLE: if (frame_req) begin m_ph = P_WAIT; m_idx = 0; m_ovf = 0; end
                P_WAIT: if (m_pend || sym_ready) begin
                    if (m_pend && sym_ready) m_ovf = 1'b1;
                    else m_pend = 1'b0;
                    m_ph = P_LOAD;
                end
                P_LOAD: begin note_sym(); m_run = 0; m_ph = P_RUN; end
                P_RUN: begin
                    note_sym();
                    if (cpi_done) begin
                        if (m_idx == N_SYM - 1) m_ph = P_FIN;
                        else begin
                            m_idx++;
                            if (GAP_CYC == 0) m_ph = P_WAIT;
                            else begin m_ph = P_GAP; m_gap = GAP_CYC; end
                        end
                    end
`ifdef SCHED_WATCHDOG_EN
                    else begin
                        m_run++;
                        if (m_run == TIMEOUT) begin
                            m_to = 1'b1; m_ph = P_IDLE; m_idx = 0; m_pend = 0;
                        end
                    end
`endif
                end
                P_GAP: begin
                    note_sym();
                    m_gap--;
                    if (m_gap == 0) m_ph = P_WAIT;
                end
                P_FIN: begin note_sym(); m_ph = P_IDLE; end
                default: m_ph = P_IDLE;
            endcase
        end
    end

    int         cyc = 0, dv_cnt = 0, fd_cnt = 0, fd_cyc = -10, fall_cyc = -20;
    logic       prev_busy = 1'b0;
    logic [5:0] idx_log [0:63];

    always @(negedge clk) begin
        logic [11:0] exp_v;
        cyc++;
        exp_v = {(m_ph == P_LOAD || m_ph == P_RUN), (m_ph == P_LOAD), (m_ph != P_IDLE),
                 (m_ph == P_FIN), m_ovf, m_to, 6'(m_idx)};
        check("cycle_outputs",
              32'({cpi_start, cpi_data_valid, busy, frame_done, overflow, timeout_err, sym_idx}),
              32'(exp_v));
        if (cpi_data_valid) begin
            if (dv_cnt < 64) idx_log[dv_cnt] = sym_idx;
            dv_cnt++;
        end
        if (frame_done) begin fd_cnt++; fd_cyc = cyc; end
        if (prev_busy && !busy) fall_cyc = cyc;
        prev_busy = busy;
    end

    // Inputs are applied on a falling edge; the task returns one cycle later,
    // when the outputs reflect the edge that sampled them.
    task automatic step(input logic fr, input logic ab, input logic sr, input logic cd);
        frame_req = fr; abort = ab; sym_ready = sr; cpi_done = cd;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "bench time limit");
    end

    initial begin
        int d0, f0;
        rst = 1'b1; frame_req = 0; abort = 0; sym_ready = 0; cpi_done = 0;
        repeat (2) @(negedge clk);
        check("reset_outputs",
              32'({cpi_start, cpi_data_valid, busy, frame_done, overflow, timeout_err, sym_idx}), 32'd0);
        rst = 1'b0;

        // Basic 3-symbol frame
        step(0, 0, 1, 0);
        check("idle_ignores_sym_ready", 32'(busy), 32'd0);
        d0 = dv_cnt; f0 = fd_cnt;
        step(1, 0, 0, 0);
        check("frame_start_busy", 32'({busy, sym_idx}), 32'h40);
        for (int s = 0; s < N_SYM; s++) begin
            step(0, 0, 1, 0);
            check("latency_load_strobe", 32'({cpi_data_valid, cpi_start}), 32'h3);
            step(1, 0, 0, 0);
            step(0, 0, 0, 1);
            if (s < N_SYM - 1) idle(GAP_CYC);
        end
        check("frame_done_pulse", 32'(frame_done), 32'd1);
        idle(2);
        check("loads_per_frame", 32'(dv_cnt - d0), 32'd3);
        check("frames_done", 32'(fd_cnt - f0), 32'd1);
        check("sym_idx_sequence", 32'({idx_log[d0], idx_log[d0+1], idx_log[d0+2]}), 32'h0042);
        check("busy_fall_after_done", 32'(fall_cyc - fd_cyc), 32'd1);

        // Symbol arriving during RUN is held and loaded after the gap
        step(1, 0, 0, 0);
        step(0, 0, 0, 1);
        check("cpi_done_in_wait_ignored", 32'({cpi_start, busy}), 32'h1);
        step(0, 0, 1, 0);
        step(0, 0, 0, 0);
        step(0, 0, 1, 0);
        step(0, 0, 0, 1);
        idle(GAP_CYC);
        step(0, 0, 0, 0);
        check("pend_load_no_new_ready", 32'({cpi_data_valid, overflow, sym_idx}), 32'h81);
        step(0, 0, 0, 0);
        step(0, 0, 0, 1);
        idle(GAP_CYC);
        step(0, 0, 1, 0);
        step(0, 0, 0, 0);
        step(0, 0, 0, 1);
        idle(1);
        check("no_overflow_single_pend", 32'({overflow, busy}), 32'h0);

        // Two extra symbols in one RUN: one dropped, overflow set
        step(1, 0, 0, 0);
        d0 = dv_cnt;
        step(0, 0, 1, 0);
        step(0, 0, 0, 0);
        step(0, 0, 1, 0);
        step(0, 0, 0, 0);
        step(0, 0, 1, 0);
        check("overflow_set", 32'(overflow), 32'd1);
        step(0, 0, 0, 1);
        idle(GAP_CYC);
        idle(2);
        step(0, 0, 0, 1);
        idle(GAP_CYC);
        idle(3);
        check("only_one_extra_load", 32'({dv_cnt - d0}), 32'd2);
        check("waiting_without_symbol", 32'({cpi_start, busy, sym_idx}), 32'h42);
        step(0, 1, 0, 0);
        check("abort_in_wait_overflow_sticky", 32'({busy, overflow}), 32'h1);

        // Abort in RUN at sym_idx=1, with a simultaneous cpi_done
        f0 = fd_cnt;
        step(1, 0, 0, 0);
        check("frame_req_clears_overflow", 32'(overflow), 32'd0);
        step(0, 0, 1, 0);
        step(0, 0, 0, 0);
        step(0, 0, 0, 1);
        idle(GAP_CYC);
        step(0, 0, 1, 0);
        step(0, 0, 0, 0);
        check("run_at_idx1", 32'({cpi_start, sym_idx}), 32'h41);
        step(0, 1, 0, 1);
        check("abort_to_idle", 32'({cpi_start, busy, sym_idx}), 32'h0);
        idle(2);
        check("abort_no_frame_done", 32'(fd_cnt - f0), 32'd0);
        step(1, 0, 0, 0);
        step(0, 0, 1, 0);
        check("restart_at_idx0", 32'({cpi_data_valid, sym_idx}), 32'h40);

        // Asynchronous reset in the middle of GAP
        step(0, 0, 0, 0);
        step(0, 0, 0, 1);
        check("in_gap_before_reset", 32'({busy, cpi_start, sym_idx}), 32'h81);
        #2 rst = 1'b1;
        #1 check("async_reset_outputs",
                 32'({cpi_start, cpi_data_valid, busy, frame_done, overflow, timeout_err, sym_idx}), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        idle(2);
        check("reset_discards_frame", 32'({busy, frame_done}), 32'd0);

`ifdef SCHED_WATCHDOG_EN
        step(1, 0, 0, 0);
        step(0, 0, 1, 0);
        step(0, 0, 0, 0);
        idle(TIMEOUT - 1);
        check("watchdog_not_yet", 32'({timeout_err, busy}), 32'h1);
        step(0, 0, 0, 0);
        check("watchdog_fired", 32'({timeout_err, busy, cpi_start}), 32'h4);
`endif

        idle(2);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
